// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter for up to 32 sources.
// Grants are one-hot and registered, a single dead cycle separates owners, and
// each grant is capped at MAX_HOLD cycles so no source can starve the others.
// The owner's "done" input is named release_bus because release is a reserved word.
module bus_arbiter #(
  parameter int unsigned N_REQ    = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N_REQ-1:0] req,
  input  logic             release_bus,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout,
  output logic [1:0]       state
);

  localparam int unsigned CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_GAP  = 2'b10,
    ST_BAD  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             end_rel, end_drop, end_hold;

  // Find the first requester at or after the pointer, wrapping 31 -> 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic; the timeout pulse defaults low every cycle.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    timeout_d  = 1'b0;
    end_rel    = release_bus;
    end_drop   = ~req[idx_q];
    end_hold   = (hold_cnt_q == HOLD_LAST);
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (win_found) begin
          state_d    = ST_BUSY;
          grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          idx_d      = win_idx;
          valid_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (end_rel || end_drop || end_hold) begin
          state_d    = ST_GAP;
          grant_d    = '0;
          idx_d      = '0;
          valid_d    = 1'b0;
          ptr_d      = idx_q + IDX_W'(1);
          hold_cnt_d = '0;
          timeout_d  = end_hold && !end_rel && !end_drop;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        idx_d      = '0;
        valid_d    = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; clear forces the idle, no-owner condition at once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed vector table, hand-written corner
// sequences, and random traffic compared against a cycle-level ownership model.
module tb_bus_arbiter;

  localparam int MAX_HOLD = 16;

  logic        clock;
  logic        clear;
  logic [31:0] req_s;
  logic        rel_s;
  logic [31:0] grant;
  logic [4:0]  grant_idx;
  logic        grant_valid;
  logic        timeout;
  logic [1:0]  state;

  int tests_run;
  int tests_failed;

  // Reference model: who owns the bus, for how many cycles, and where the search starts.
  int m_owner;
  int m_held;
  int m_ptr;
  bit m_gap;
  bit m_timeout;

  typedef struct {
    logic [31:0] req;
    logic        rel;
    logic [31:0] grant;
    logic [4:0]  idx;
    logic        valid;
    logic        tmo;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[18];

  bus_arbiter #(.N_REQ(32), .IDX_W(5), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock),
    .clear(clear),
    .req(req_s),
    .release_bus(rel_s),
    .grant(grant),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid),
    .timeout(timeout),
    .state(state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_owner   = -1;
    m_held    = 0;
    m_ptr     = 0;
    m_gap     = 1'b0;
    m_timeout = 1'b0;
  endtask

  function automatic int winnerOf(input logic [31:0] r, input int ptr);
    for (int k = 0; k < 32; k++) begin
      if (r[(ptr + k) % 32]) return (ptr + k) % 32;
    end
    return -1;
  endfunction

  // One rising edge of the model, seeing the inputs present at that edge.
  task automatic modelStep(input logic [31:0] r, input logic rl);
    int w;
    if (m_owner >= 0) begin
      if (rl || !r[m_owner] || m_held == MAX_HOLD) begin
        m_timeout = !rl && r[m_owner];
        m_ptr     = (m_owner + 1) % 32;
        m_owner   = -1;
        m_gap     = 1'b1;
      end else begin
        m_held++;
        m_timeout = 1'b0;
      end
    end else begin
      m_timeout = 1'b0;
      m_gap     = 1'b0;
      w = winnerOf(r, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
      end
    end
  endtask

  task automatic checkOutput();
    logic [31:0] eg;
    logic [4:0]  ei;
    logic [1:0]  es;
    eg = (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0;
    ei = (m_owner >= 0) ? 5'(m_owner) : 5'd0;
    es = (m_owner >= 0) ? 2'b01 : (m_gap ? 2'b10 : 2'b00);
    check("grant", grant, eg);
    check("grant_idx", 32'(grant_idx), 32'(ei));
    check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_timeout));
    check("state", 32'(state), 32'(es));
    check("inv_onehot0", 32'($onehot0(grant)), 32'd1);
    check("inv_valid", 32'(grant_valid), 32'(|grant));
    check("inv_idx_enc", (grant == 32'h0) ? 32'(grant_idx) : (32'h1 << grant_idx),
          (grant == 32'h0) ? 32'h0 : grant);
  endtask

  // Drive inputs, take one edge, advance the model, then sample 1 ns after the edge.
  task automatic applyStimulus(input logic [31:0] r, input logic rl);
    req_s = r;
    rel_s = rl;
    @(posedge clock);
    modelStep(r, rl);
    #1;
    checkOutput();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    modelReset();

    vecs[0]  = '{32'h0000_0100, 1'b0, 32'h0000_0100, 5'd8,  1'b1, 1'b0, 2'b01};
    vecs[1]  = '{32'h0000_0100, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 2'b10};
    vecs[2]  = '{32'h0,         1'b0, 32'h0,         5'd0,  1'b0, 1'b0, 2'b00};
    vecs[3]  = '{32'h8000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 2'b01};
    vecs[4]  = '{32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 2'b10};
    vecs[5]  = '{32'h8000_0001, 1'b0, 32'h0000_0001, 5'd0,  1'b1, 1'b0, 2'b01};
    vecs[6]  = '{32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 2'b10};
    vecs[7]  = '{32'h8000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 2'b01};
    vecs[8]  = '{32'h8000_0001, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 2'b10};
    vecs[9]  = '{32'h8000_0003, 1'b0, 32'h0000_0001, 5'd0,  1'b1, 1'b0, 2'b01};
    vecs[10] = '{32'h8000_0003, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 2'b10};
    vecs[11] = '{32'h8000_0003, 1'b0, 32'h0000_0002, 5'd1,  1'b1, 1'b0, 2'b01};
    vecs[12] = '{32'h8000_0003, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 2'b10};
    vecs[13] = '{32'h8000_0003, 1'b0, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 2'b01};
    vecs[14] = '{32'h8000_0003, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 2'b10};
    vecs[15] = '{32'h8000_0003, 1'b0, 32'h0000_0001, 5'd0,  1'b1, 1'b0, 2'b01};
    vecs[16] = '{32'h8000_0003, 1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 2'b10};
    vecs[17] = '{32'h0,         1'b1, 32'h0,         5'd0,  1'b0, 1'b0, 2'b00};

    // Reset state, entered asynchronously before any clock edge.
    clear = 1'b1;
    req_s = 32'h0;
    rel_s = 1'b0;
    #2 clear = 1'b0;
    #1;
    checkOutput();
    @(negedge clock);
    clear = 1'b1;

    // Directed table: single request, round robin 0/31, pointer wrap 0,1,31,0.
    for (int v = 0; v < 18; v++) begin
      applyStimulus(vecs[v].req, vecs[v].rel);
      check($sformatf("vec%0d_grant", v), grant, vecs[v].grant);
      check($sformatf("vec%0d_idx", v), 32'(grant_idx), 32'(vecs[v].idx));
      check($sformatf("vec%0d_valid", v), 32'(grant_valid), 32'(vecs[v].valid));
      check($sformatf("vec%0d_timeout", v), 32'(timeout), 32'(vecs[v].tmo));
      check($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].st));
    end

    // Hold timeout: sole requester 2 held without release gets exactly 16 cycles.
    for (int c = 0; c < MAX_HOLD; c++) begin
      applyStimulus(32'h4, 1'b0);
      check("hold_grant", grant, 32'h4);
    end
    applyStimulus(32'h4, 1'b0);
    check("hold_gap_grant", grant, 32'h0);
    check("hold_gap_timeout", 32'(timeout), 32'd1);
    applyStimulus(32'h4, 1'b0);
    check("hold_regrant", grant, 32'h4);
    check("hold_regrant_timeout", 32'(timeout), 32'd0);
    // Release on the final allowed cycle wins over the limit: no timeout pulse.
    for (int c = 1; c < MAX_HOLD; c++) applyStimulus(32'h4, 1'b0);
    check("limit_last_grant", grant, 32'h4);
    applyStimulus(32'h4, 1'b1);
    check("limit_rel_state", 32'(state), 32'd2);
    check("limit_rel_timeout", 32'(timeout), 32'd0);
    applyStimulus(32'h0, 1'b0);
    check("limit_idle", 32'(state), 32'd0);

    // Owner 3 drops its request while 7 waits: gap, then 7 is served.
    applyStimulus(32'h88, 1'b0);
    check("drop_owner", 32'(grant_idx), 32'd3);
    applyStimulus(32'h80, 1'b0);
    check("drop_gap", 32'(state), 32'd2);
    applyStimulus(32'h80, 1'b0);
    check("drop_next", 32'(grant_idx), 32'd7);
    applyStimulus(32'h80, 1'b1);
    applyStimulus(32'h0, 1'b0);

    // Request present for one cycle only: one-cycle grant, gap, idle.
    applyStimulus(32'h10, 1'b0);
    check("short_grant", grant, 32'h10);
    applyStimulus(32'h0, 1'b0);
    check("short_gap", 32'(state), 32'd2);
    check("short_timeout", 32'(timeout), 32'd0);
    applyStimulus(32'h0, 1'b0);
    check("short_idle", 32'(state), 32'd0);

    // Asynchronous clear in the middle of a grant to source 5.
    applyStimulus(32'h20, 1'b0);
    check("rst_pre_idx", 32'(grant_idx), 32'd5);
    #2 clear = 1'b0;
    #1;
    modelReset();
    check("rst_async_grant", grant, 32'h0);
    check("rst_async_idx", 32'(grant_idx), 32'd0);
    check("rst_async_valid", 32'(grant_valid), 32'd0);
    check("rst_async_state", 32'(state), 32'd0);
    #1 clear = 1'b1;
    applyStimulus(32'h20, 1'b0);
    check("rst_after_grant", grant, 32'h20);
    check("rst_after_idx", 32'(grant_idx), 32'd5);

    // Random traffic: sparse request patterns held for a while, occasional releases.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r;
      r = req_s;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: r = 32'h0;
          1: r = 32'h1 << $urandom_range(0, 31);
          2: r = $urandom & $urandom & $urandom;
          default: r = $urandom;
        endcase
      end
      applyStimulus(r, ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
